imuldiv_div_arbiter: RTL and testbench

//  Shares one imuldiv_IntDivIterative unit among NREQ requesters, using round-robin arbitration.

---
 rtl/imuldiv_div_arbiter_pkg.sv | 24 ++
 rtl/imuldiv_div_arbiter_rrarb.sv | 28 ++
 rtl/imuldiv_div_arbiter.sv | 123 ++++++++++++
 tb/tb_imuldiv_div_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_div_arbiter_pkg.sv
// Shared types for the divider arbiter: FSM encoding, divider message and result layout.
package imuldiv_div_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] quot;
    } div_result_t;

    typedef struct packed {
        logic        fn;
        logic [31:0] a;
        logic [31:0] b;
    } div_msg_t;

endpackage

// File: rtl/imuldiv_div_arbiter_rrarb.sv
// Combinational round-robin pick: first valid requester scanning from ptr upward, wrapping mod NREQ.
module imuldiv_RRArbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_val_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   winner_o,
    output logic            any_val_o
);

    int idx;

    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        winner_o  = '0;
        any_val_o = 1'b0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (req_val_i[idx]) begin
                winner_o  = PW'(idx);
                any_val_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imuldiv_div_arbiter.sv
// Round-robin share of one iterative divider among NREQ lanes, one transaction in flight; 3 cycles overhead.
// Backpressure holds the response until the owner takes it. IMULDIV_ARB_DIV0_BYPASS_EN answers b==0 locally.
module imuldiv_div_arbiter
    import imuldiv_div_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_msg_fn,
    input  logic [32*NREQ-1:0] req_msg_a,
    input  logic [32*NREQ-1:0] req_msg_b,
    input  logic [NREQ-1:0]    req_val,
    output logic [NREQ-1:0]    req_rdy,
    output logic [63:0]        resp_msg_result,
    output logic [NREQ-1:0]    resp_val,
    input  logic [NREQ-1:0]    resp_rdy,
    output logic               divreq_msg_fn,
    output logic [31:0]        divreq_msg_a,
    output logic [31:0]        divreq_msg_b,
    output logic               divreq_val,
    input  logic               divreq_rdy,
    input  logic [63:0]        divresp_msg_result,
    input  logic               divresp_val,
    output logic               divresp_rdy
);

    state_e      state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    div_msg_t    msg_q, msg_d;
    div_result_t result_q, result_d;

    logic [PW-1:0] winner;
    logic          any_val;
    logic          win_fn;
    logic [31:0]   win_a, win_b;

    imuldiv_RRArbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req_val_i (req_val),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_val_o (any_val)
    );

    assign win_fn = req_msg_fn[winner];
    assign win_a  = req_msg_a[32*int'(winner) +: 32];
    assign win_b  = req_msg_b[32*int'(winner) +: 32];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        msg_d       = msg_q;
        result_d    = result_q;
        req_rdy     = '0;
        resp_val    = '0;
        divreq_val  = 1'b0;
        divresp_rdy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Grant is suppressed while reset is held so every output reads 0 in reset.
                if (any_val && reset) begin
                    req_rdy[winner] = 1'b1;
                    owner_d         = winner;
                    msg_d           = '{fn: win_fn, a: win_a, b: win_b};
`ifdef IMULDIV_ARB_DIV0_BYPASS_EN
                    if (win_b == '0) begin
                        result_d = '{rem: win_a, quot: DIV0_QUOT};
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_ISSUE;
                    end
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                divreq_val = 1'b1;
                if (divreq_rdy) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                divresp_rdy = 1'b1;
                if (divresp_val) begin
                    result_d = div_result_t'(divresp_msg_result);
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_val[owner_q] = 1'b1;
                if (resp_rdy[owner_q]) begin
                    ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            msg_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            msg_q    <= msg_d;
            result_q <= result_d;
        end
    end

    assign divreq_msg_fn   = msg_q.fn;
    assign divreq_msg_a    = msg_q.a;
    assign divreq_msg_b    = msg_q.b;
    assign resp_msg_result = result_q;

endmodule

// File: tb/tb_imuldiv_div_arbiter.sv
// Directed bench for imuldiv_div_arbiter (NREQ=2 with a divider model, NREQ=3 with a tied-off divider).
// Expectations for b==0 follow IMULDIV_ARB_DIV0_BYPASS_EN when defined.
module tb_imuldiv_div_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  req_msg_fn, req_val, req_rdy, resp_val, resp_rdy;
    logic [63:0] req_msg_a, req_msg_b, resp_msg_result;
    logic        divreq_msg_fn, divreq_val, divreq_rdy;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic [63:0] divresp_msg_result;
    logic        divresp_val, divresp_rdy;

    logic [2:0]  r3_fn, r3_val, r3_rdy, r3_resp_val, r3_resp_rdy;
    logic [95:0] r3_a, r3_b;
    logic [63:0] r3_result, d3_resp_res;
    logic        d3_fn, d3_val, d3_rdy, d3_resp_val, d3_resp_rdy;
    logic [31:0] d3_a, d3_b;

    imuldiv_div_arbiter #(.NREQ(2), .PW(1)) dut (
        .clk(clk), .reset(reset),
        .req_msg_fn(req_msg_fn), .req_msg_a(req_msg_a), .req_msg_b(req_msg_b),
        .req_val(req_val), .req_rdy(req_rdy),
        .resp_msg_result(resp_msg_result), .resp_val(resp_val), .resp_rdy(resp_rdy),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy)
    );

    imuldiv_div_arbiter #(.NREQ(3), .PW(2)) dut3 (
        .clk(clk), .reset(reset),
        .req_msg_fn(r3_fn), .req_msg_a(r3_a), .req_msg_b(r3_b),
        .req_val(r3_val), .req_rdy(r3_rdy),
        .resp_msg_result(r3_result), .resp_val(r3_resp_val), .resp_rdy(r3_resp_rdy),
        .divreq_msg_fn(d3_fn), .divreq_msg_a(d3_a), .divreq_msg_b(d3_b),
        .divreq_val(d3_val), .divreq_rdy(d3_rdy),
        .divresp_msg_result(d3_resp_res), .divresp_val(d3_resp_val), .divresp_rdy(d3_resp_rdy)
    );

    function automatic logic [63:0] ref_div(input logic fn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF; r = a;
        end else if (fn && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = a; r = 32'd0;
        end else if (fn) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        return {r, q};
    endfunction

    // Small divider model: fixed latency, shares the arbiter reset.
    logic dv_busy;
    int   dv_cnt;
    assign divreq_rdy = !dv_busy;
    always @(posedge clk) begin
        if (!reset) begin
            dv_busy <= 1'b0; dv_cnt <= 0; divresp_val <= 1'b0; divresp_msg_result <= '0;
        end else if (!dv_busy) begin
            if (divreq_val) begin
                dv_busy <= 1'b1; dv_cnt <= 4;
                divresp_msg_result <= ref_div(divreq_msg_fn, divreq_msg_a, divreq_msg_b);
            end
        end else if (divresp_val) begin
            if (divresp_rdy) begin divresp_val <= 1'b0; dv_busy <= 1'b0; end
        end else if (dv_cnt == 0) begin
            divresp_val <= 1'b1;
        end else begin
            dv_cnt <= dv_cnt - 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] resp_or;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        resp_or = '0;
        while (resp_val == 2'b00 && n < 200) begin
            tick; n++;
            resp_or = resp_or | resp_val;
        end
        chk({tag, "_timeout"}, 64'(n < 200), 64'd1);
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (req_rdy == 2'b00 && n < 200) begin tick; n++; end
        chk({tag, "_timeout"}, 64'(n < 200), 64'd1);
    endtask

    task automatic wait_r3(input string tag);
        int n = 0;
        while (r3_resp_val == 3'b000 && n < 200) begin tick; n++; end
        chk({tag, "_timeout"}, 64'(n < 200), 64'd1);
    endtask

    initial begin
        reset = 1'b0;
        req_msg_fn = 2'b01; req_msg_a = {32'd0, 32'hFFFFFFF9}; req_msg_b = {32'd0, 32'd2};
        req_val = 2'b01; resp_rdy = 2'b11;
        r3_fn = '0; r3_a = '0; r3_b = '0; r3_val = '0; r3_resp_rdy = 3'b111;
        d3_rdy = 1'b1; d3_resp_val = 1'b1; d3_resp_res = 64'h0000_0001_0000_1234;
        repeat (2) tick;

        // Reset state, with a request already pending
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_resp_val", 64'(resp_val), 64'd0);
        chk("rst_divreq_val", 64'(divreq_val), 64'd0);
        chk("rst_divresp_rdy", 64'(divresp_rdy), 64'd0);
        chk("rst_result", resp_msg_result, 64'd0);
        chk("rst_divreq_a", 64'(divreq_msg_a), 64'd0);

        // Test 1: port0 signed -7 / 2
        reset = 1'b1; #1;
        chk("t1_req_rdy", 64'(req_rdy), 64'd1);
        tick; req_val = 2'b00;
        chk("t1_divreq_val", 64'(divreq_val), 64'd1);
        chk("t1_divreq_a", 64'(divreq_msg_a), 64'hFFFFFFF9);
        chk("t1_divreq_fn", 64'(divreq_msg_fn), 64'd1);
        wait_resp("t1");
        chk("t1_resp_val", 64'(resp_val), 64'd1);
        chk("t1_resp_or", 64'(resp_or), 64'd1);
        chk("t1_result", resp_msg_result, 64'hFFFFFFFF_FFFFFFFD);
        tick;
        chk("t1_resp_done", 64'(resp_val), 64'd0);

        // Test 3: port1 50/7 with response backpressure
        req_msg_fn[1] = 1'b0; req_msg_a[63:32] = 32'd50; req_msg_b[63:32] = 32'd7;
        req_val = 2'b10; resp_rdy = 2'b01; #1;
        chk("t3_req_rdy", 64'(req_rdy), 64'd2);
        tick; req_val = 2'b00;
        wait_resp("t3");
        chk("t3_resp_val", 64'(resp_val), 64'd2);
        chk("t3_result", resp_msg_result, 64'h00000001_00000007);
        req_msg_fn = 2'b10; req_msg_a = {32'hFFFFFFEC, 32'd1000}; req_msg_b = {32'd3, 32'd10};
        req_val = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("t3_hold_val", 64'(resp_val), 64'd2);
            chk("t3_hold_res", resp_msg_result, 64'h00000001_00000007);
            chk("t3_hold_req_rdy", 64'(req_rdy), 64'd0);
            chk("t3_hold_divreq", 64'(divreq_val), 64'd0);
        end
        resp_rdy = 2'b11;
        tick;

        // Test 2: continuous contention, grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  exp_own;
            logic [63:0] exp_res;
            exp_own = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_res = (i % 2 == 0) ? 64'h00000000_00000064 : 64'hFFFFFFFE_FFFFFFFA;
            wait_rdy("t2_rdy");
            chk("t2_grant", 64'(req_rdy), 64'(exp_own));
            tick;
            wait_resp("t2_resp");
            chk("t2_resp_val", 64'(resp_val), 64'(exp_own));
            chk("t2_result", resp_msg_result, exp_res);
            tick;
        end
        req_val = 2'b00;

        // Test 4: reset while waiting on the divider
        req_msg_fn = 2'b00; req_msg_a = {32'd0, 32'd5}; req_msg_b = {32'd0, 32'd1};
        req_val = 2'b01;
        tick; req_val = 2'b00;
        for (int n = 0; n < 20 && !divresp_rdy; n++) tick;
        chk("t4_in_wait", 64'(divresp_rdy), 64'd1);
        reset = 1'b0;
        tick;
        chk("t4_req_rdy", 64'(req_rdy), 64'd0);
        chk("t4_resp_val", 64'(resp_val), 64'd0);
        chk("t4_divreq_val", 64'(divreq_val), 64'd0);
        chk("t4_divresp_rdy", 64'(divresp_rdy), 64'd0);
        chk("t4_result", resp_msg_result, 64'd0);
        chk("t4_divreq_a", 64'(divreq_msg_a), 64'd0);
        reset = 1'b1;
        req_msg_a = {32'hFFFFFFFF, 32'd0}; req_msg_b = {32'd16, 32'd0}; req_val = 2'b10; #1;
        chk("t4_req_rdy2", 64'(req_rdy), 64'd2);
        tick; req_val = 2'b00;
        wait_resp("t4");
        chk("t4_resp_val2", 64'(resp_val), 64'd2);
        chk("t4_result2", resp_msg_result, 64'h0000000F_0FFFFFFF);
        tick;

        // Test 5: divide by zero
        req_msg_fn = 2'b00; req_msg_a = {32'd0, 32'd100}; req_msg_b = '0; req_val = 2'b01; #1;
        chk("t5_req_rdy", 64'(req_rdy), 64'd1);
        tick; req_val = 2'b00;
`ifdef IMULDIV_ARB_DIV0_BYPASS_EN
        chk("t5_resp_val", 64'(resp_val), 64'd1);
        chk("t5_divreq_val", 64'(divreq_val), 64'd0);
        chk("t5_result", resp_msg_result, 64'h00000064_FFFFFFFF);
`else
        chk("t5_divreq_val", 64'(divreq_val), 64'd1);
        chk("t5_divreq_b", 64'(divreq_msg_b), 64'd0);
        wait_resp("t5");
        chk("t5_resp_val", 64'(resp_val), 64'd1);
        chk("t5_result", resp_msg_result, 64'h00000064_FFFFFFFF);
`endif
        tick;

        // Test 6: NREQ=3, pointer moves to 2 after serving port1
        r3_a[63:32] = 32'd9; r3_b[63:32] = 32'd3; r3_val = 3'b010; #1;
        chk("t6_rdy1", 64'(r3_rdy), 64'd2);
        tick; r3_val = 3'b000;
        wait_r3("t6_a");
        chk("t6_resp1", 64'(r3_resp_val), 64'd2);
        chk("t6_result", r3_result, 64'h0000_0001_0000_1234);
        tick;
        r3_val = 3'b101; #1;
        chk("t6_rdy2", 64'(r3_rdy), 64'd4);
        tick;
        wait_r3("t6_b");
        chk("t6_resp2", 64'(r3_resp_val), 64'd4);
        tick;
        chk("t6_rdy0", 64'(r3_rdy), 64'd1);
        r3_val = 3'b000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
